// File: rtl/psdsqrt_seq.sv
// Sequencer for the psdsqrt core: takes operands on a valid/ready stream, runs the
// start/iterate/stop handshake, and returns root plus operand on a valid/ready stream.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | ready for an operand; in_valid loads x_q
// S_START | one-cycle sq_start pulse, iteration counter cleared
// S_RUN   | ITER_CYCLES cycles while the core iterates
// S_STOP  | one-cycle sq_stop pulse; the core latches its root on this edge
// S_CAPT  | root sampled from the core into res_q
// S_OUT   | result offered downstream until out_ready
module psdsqrt_seq #(
  parameter int XW          = 32,
  parameter int RW          = 16,
  parameter int ITER_CYCLES = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] in_x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_sqrt,
  output logic [XW-1:0] out_x,
  output logic          busy,
  output logic          sq_start,
  output logic          sq_stop,
  output logic [XW-1:0] sq_x,
  input  logic [RW-1:0] sq_sqrt
);

  localparam int CNT_W = $clog2(ITER_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_STOP,
    S_CAPT,
    S_OUT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XW-1:0]    x_q, x_d;
  logic [RW-1:0]    res_q, res_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // Counter is one bit wider than needed so the final increment cannot wrap.
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER_CYCLES - 1)) state_d = S_STOP;
      end
      S_STOP: state_d = S_CAPT;
      S_CAPT: begin
        res_d   = sq_sqrt;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Every output is a state decode or a flop, so the streams have no comb paths.
  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign sq_start  = (state_q == S_START);
  assign sq_stop   = (state_q == S_STOP);
  assign out_valid = (state_q == S_OUT);
  assign sq_x      = x_q;
  assign out_x     = x_q;
  assign out_sqrt  = res_q;

endmodule
